// File: rtl/cve2_pmp_chk_arb_if.sv
// Bundle of the requester, PMP checker and status signals around
// cve2_pmp_chk_arb.
//   slave  : the arbiter side (takes requests, drives chk_*/rsp_*/status)
//   master : the environment side (requesters, PMP checker, CSR unit)
// Signals:
//   req_valid_i/req_ready_o          per-requester request handshake
//   req_addr_i/req_type_i/req_priv_i packed per-requester payload
//   chk_addr_o/chk_type_o/chk_priv_o checker channel, chk_err_i its result
//   csr_pmp_update_i                 PMP CSR write strobe
//   rsp_valid_o/rsp_ready_i          per-requester response handshake
//   rsp_err_o                        fault result of the response
//   busy_o, err_cnt_o                status
interface cve2_pmp_chk_arb_if #(
    parameter int unsigned NumReq      = 3,
    parameter int unsigned AddrWidth   = 34,
    parameter int unsigned ErrCntWidth = 16
);
    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq*AddrWidth-1:0] req_addr_i;
    logic [NumReq*2-1:0]         req_type_i;
    logic [NumReq*2-1:0]         req_priv_i;
    logic [AddrWidth-1:0]        chk_addr_o;
    logic [1:0]                  chk_type_o;
    logic [1:0]                  chk_priv_o;
    logic                        chk_err_i;
    logic                        csr_pmp_update_i;
    logic [NumReq-1:0]           rsp_valid_o;
    logic [NumReq-1:0]           rsp_ready_i;
    logic                        rsp_err_o;
    logic                        busy_o;
    logic [ErrCntWidth-1:0]      err_cnt_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_type_i, req_priv_i,
               chk_err_i, csr_pmp_update_i, rsp_ready_i,
        output req_ready_o, chk_addr_o, chk_type_o, chk_priv_o,
               rsp_valid_o, rsp_err_o, busy_o, err_cnt_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_type_i, req_priv_i,
               chk_err_i, csr_pmp_update_i, rsp_ready_i,
        input  req_ready_o, chk_addr_o, chk_type_o, chk_priv_o,
               rsp_valid_o, rsp_err_o, busy_o, err_cnt_o
    );
endinterface

// File: rtl/cve2_pmp_chk_arb.sv
// Round-robin arbiter/sequencer sharing one PMP check channel among NumReq
// requesters. A granted request is latched onto the chk_* outputs, the
// checker result is sampled (and re-sampled while PMP CSRs are being
// written), then a registered response is returned to the winner.
// Faulting responses are counted in a saturating counter.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    cve2_pmp_chk_arb_if slave modport (requests, checker, responses)
module cve2_pmp_chk_arb #(
    parameter int unsigned NumReq      = 3,
    parameter int unsigned AddrWidth   = 34,
    parameter int unsigned ErrCntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cve2_pmp_chk_arb_if.slave   bus
);
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP
    } state_e;

    state_e                 state;
    logic [IdxW-1:0]        rr_ptr;
    logic [IdxW-1:0]        owner;
    logic [IdxW-1:0]        grant_idx;
    logic                   grant_any;
    int unsigned            scan_idx;
    logic [NumReq-1:0]      ready;
    logic [NumReq-1:0]      rsp_valid;
    logic [AddrWidth-1:0]   chk_addr;
    logic [1:0]             chk_type;
    logic [1:0]             chk_priv;
    logic                   err_q;
    logic                   busy;
    logic [ErrCntWidth-1:0] err_cnt;

    // First valid requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            scan_idx = 32'(rr_ptr) + k;
            if (scan_idx >= NumReq) begin
                scan_idx = scan_idx - NumReq;
            end
            if (!grant_any && bus.req_valid_i[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = IdxW'(scan_idx);
            end
        end
    end

    // Ready is combinational so the handshake completes in the grant cycle;
    // it is suppressed during reset so nothing is accepted then.
    always_comb begin
        ready = '0;
        if (state == IDLE && grant_any && !rst_i) begin
            ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            chk_addr  <= '0;
            chk_type  <= '0;
            chk_priv  <= '0;
            rsp_valid <= '0;
            err_q     <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner    <= grant_idx;
                        chk_addr <= bus.req_addr_i[grant_idx*AddrWidth +: AddrWidth];
                        chk_type <= bus.req_type_i[grant_idx*2 +: 2];
                        chk_priv <= bus.req_priv_i[grant_idx*2 +: 2];
                        rr_ptr   <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    // A CSR write this cycle invalidates the result; keep the
                    // payload on chk_* so the check repeats next cycle.
                    if (!bus.csr_pmp_update_i) begin
                        err_q     <= bus.chk_err_i;
                        chk_addr  <= '0;
                        chk_type  <= '0;
                        chk_priv  <= '0;
                        rsp_valid <= NumReq'(1) << owner;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i[owner]) begin
                        if (err_q && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        rsp_valid <= '0;
                        err_q     <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.chk_addr_o  = chk_addr;
    assign bus.chk_type_o  = chk_type;
    assign bus.chk_priv_o  = chk_priv;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_err_o   = err_q;
    assign bus.busy_o      = busy;
    assign bus.err_cnt_o   = err_cnt;
endmodule

// File: tb/tb_cve2_pmp_chk_arb.sv
// Self-checking bench for cve2_pmp_chk_arb (NumReq=3, AddrWidth=34,
// ErrCntWidth=2). A transaction-level model tracks the round-robin pointer
// and the saturating fault count; every cycle of every transaction is
// checked against it.
module tb_cve2_pmp_chk_arb;
    localparam int unsigned N    = 3;
    localparam int unsigned AW   = 34;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cve2_pmp_chk_arb_if #(.NumReq(N), .AddrWidth(AW), .ErrCntWidth(CW)) bus ();

    cve2_pmp_chk_arb #(.NumReq(N), .AddrWidth(AW), .ErrCntWidth(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state
    int m_rr  = 0;
    int m_cnt = 0;

    logic [AW-1:0] pa [N];
    logic [1:0]    pt [N];
    logic [1:0]    pp [N];
    logic [N-1:0]  obs_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            pa[i] = AW'({$urandom(), $urandom()});
            pt[i] = 2'($urandom_range(0, 2));
            pp[i] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", bus.req_ready_o, 0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_rsp_err",   bus.rsp_err_o, 0);
        check("rst_busy",      bus.busy_o, 0);
        check("rst_chk_addr",  bus.chk_addr_o, 0);
        check("rst_chk_type",  bus.chk_type_o, 0);
        check("rst_chk_priv",  bus.chk_priv_o, 0);
        check("rst_err_cnt",   bus.err_cnt_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid_i = '0;
        @(negedge clk);
        rst = 1'b0;
        m_rr  = 0;
        m_cnt = 0;
    endtask

    // One full transaction, cycle-exact from the grant cycle to the response
    // handshake. csr_n: update cycles in CHECK; eb/ea: checker result before
    // and after the update; stall: cycles with the owner's rsp_ready low.
    task automatic run_txn(input logic [N-1:0] valid, input int csr_n, input bit eb,
                           input bit ea, input int stall, input bit rst_resp);
        int           g;
        bit           exp_err;
        logic [N-1:0] oh;
        @(negedge clk);
        check("idle_busy", bus.busy_o, 0);
        check("idle_rsp_valid", bus.rsp_valid_o, 0);
        check("err_cnt", bus.err_cnt_o, m_cnt);
        for (int i = 0; i < N; i++) begin
            bus.req_addr_i[i*AW +: AW] = pa[i];
            bus.req_type_i[i*2 +: 2]   = pt[i];
            bus.req_priv_i[i*2 +: 2]   = pp[i];
        end
        bus.req_valid_i      = valid;
        bus.chk_err_i        = eb;
        bus.csr_pmp_update_i = 1'b0;
        bus.rsp_ready_i      = '1;
        #1;
        g  = model_grant(valid);
        oh = N'(1) << g;
        obs_ready = bus.req_ready_o;
        check("req_ready", bus.req_ready_o, oh);
        m_rr = (g + 1) % N;

        @(negedge clk);
        bus.csr_pmp_update_i = (csr_n > 0);
        #1;
        check("chk_addr", bus.chk_addr_o, pa[g]);
        check("chk_type", bus.chk_type_o, pt[g]);
        check("chk_priv", bus.chk_priv_o, pp[g]);
        check("check_busy", bus.busy_o, 1);
        check("check_req_ready", bus.req_ready_o, 0);
        check("check_rsp_valid", bus.rsp_valid_o, 0);

        for (int i = 0; i < csr_n; i++) begin
            @(negedge clk);
            bus.csr_pmp_update_i = (i + 1 < csr_n);
            bus.chk_err_i        = ea;
            #1;
            check("csr_rsp_valid", bus.rsp_valid_o, 0);
            check("csr_chk_addr", bus.chk_addr_o, pa[g]);
            check("csr_busy", bus.busy_o, 1);
        end
        exp_err = (csr_n > 0) ? ea : eb;

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            bus.csr_pmp_update_i = 1'($urandom_range(0, 1));
            bus.chk_err_i        = 1'($urandom_range(0, 1));
            bus.rsp_ready_i      = (N'($urandom()) & ~oh) | ((s == stall) ? oh : '0);
            #1;
            check("rsp_valid", bus.rsp_valid_o, oh);
            check("rsp_err", bus.rsp_err_o, exp_err);
            check("rsp_req_ready", bus.req_ready_o, 0);
            check("rsp_chk_addr", bus.chk_addr_o, 0);
            check("rsp_busy", bus.busy_o, 1);
            if (rst_resp) begin
                rst = 1'b1;
                @(negedge clk);
                #1;
                check_reset_outputs();
                rst = 1'b0;
                bus.req_valid_i = '0;
                m_rr  = 0;
                m_cnt = 0;
                return;
            end
        end
        if (exp_err && m_cnt < CMAX) m_cnt++;
    endtask

    initial begin
        bus.req_valid_i      = '1;
        bus.req_addr_i       = '0;
        bus.req_type_i       = '0;
        bus.req_priv_i       = '0;
        bus.chk_err_i        = 1'b0;
        bus.csr_pmp_update_i = 1'b0;
        bus.rsp_ready_i      = '1;
        rst = 1'b1;

        // Reset state, with all requesters valid to show ready is held low
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        bus.req_valid_i = '0;

        // Single request from requester 1
        rand_payload();
        pa[1] = 34'h0_0000_1000;
        pt[1] = 2'b10;
        pp[1] = 2'b11;
        run_txn(3'b010, 0, 1'b0, 1'b0, 0, 1'b0);
        check("single_grant", obs_ready, 3'b010);

        // Round-robin with all requesters valid
        do_reset();
        rand_payload();
        run_txn(3'b111, 0, 1'b0, 1'b0, 0, 1'b0);
        check("rr_grant0", obs_ready, 3'b001);
        run_txn(3'b111, 0, 1'b0, 1'b0, 0, 1'b0);
        check("rr_grant1", obs_ready, 3'b010);
        run_txn(3'b111, 0, 1'b0, 1'b0, 0, 1'b0);
        check("rr_grant2", obs_ready, 3'b100);
        run_txn(3'b111, 0, 1'b0, 1'b0, 0, 1'b0);
        check("rr_grant_wrap", obs_ready, 3'b001);

        // CSR update during CHECK: stale fault discarded
        rand_payload();
        run_txn(3'b001, 2, 1'b1, 1'b0, 0, 1'b0);

        // Backpressure with a faulting result
        rand_payload();
        run_txn(3'b100, 0, 1'b1, 1'b1, 5, 1'b0);

        // Reset while in RESP, then a fresh request from requester 2
        rand_payload();
        run_txn(3'b011, 0, 1'b1, 1'b0, 2, 1'b1);
        rand_payload();
        run_txn(3'b100, 0, 1'b0, 1'b0, 0, 1'b0);
        check("post_rst_grant", obs_ready, 3'b100);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [N-1:0] v;
            v = N'($urandom_range(1, 7));
            rand_payload();
            run_txn(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        // Counter saturation: five faulting checks
        do_reset();
        for (int n = 0; n < 5; n++) begin
            rand_payload();
            run_txn(N'($urandom_range(1, 7)), 0, 1'b1, 1'b1, 0, 1'b0);
        end
        @(negedge clk);
        #1;
        check("final_busy", bus.busy_o, 0);
        check("final_err_cnt", bus.err_cnt_o, m_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
